// File: rtl/egress_pkg.sv
// Shared definitions for the two-port router egress stage: state encoding,
// default data width and burst counter width.
package egress_pkg;

   localparam int EGRESS_DATA_W = 8;
   localparam int BURST_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SERVE0 = 2'd1,
      ST_SERVE1 = 2'd2
   } state_t;

endpackage

// File: rtl/egress_arbiter_2to1_arb.sv
// Round-robin arbiter with bounded bursts: picks which output FIFO to pop and
// issues the pop requests, holding off while the egress sink is almost full.
module rr_burst_arbiter
   import egress_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic fifo0_empty,
   input  logic fifo1_empty,
   input  logic down_almost_full,
   output logic read0,
   output logic read1
);

   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

   state_t             state_q, state_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic               ptr_q, ptr_d;

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      ptr_d   = ptr_q;
      read0   = 1'b0;
      read1   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo0_empty || !fifo1_empty) begin
               burst_d = '0;
               // Priority source first if it has data, otherwise the other one
               if (ptr_q ? fifo1_empty : !fifo0_empty) state_d = ST_SERVE0;
               else                                    state_d = ST_SERVE1;
            end
         end
         ST_SERVE0: begin
            read0 = !fifo0_empty && !down_almost_full;
            if (fifo0_empty) begin
               ptr_d   = 1'b1;
               burst_d = '0;
               state_d = fifo1_empty ? ST_IDLE : ST_SERVE1;
            end else if (read0) begin
               if (burst_q == BURST_LAST) begin
                  burst_d = '0;
                  if (!fifo1_empty) begin
                     state_d = ST_SERVE1;
                     ptr_d   = 1'b1;
                  end
               end else begin
                  burst_d = burst_q + BURST_W'(1);
               end
            end
         end
         ST_SERVE1: begin
            read1 = !fifo1_empty && !down_almost_full;
            if (fifo1_empty) begin
               ptr_d   = 1'b0;
               burst_d = '0;
               state_d = fifo0_empty ? ST_IDLE : ST_SERVE0;
            end else if (read1) begin
               if (burst_q == BURST_LAST) begin
                  burst_d = '0;
                  if (!fifo0_empty) begin
                     state_d = ST_SERVE0;
                     ptr_d   = 1'b0;
                  end
               end else begin
                  burst_d = burst_q + BURST_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         burst_q <= '0;
         ptr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: rtl/egress_arbiter_2to1.sv
// Egress stage: merges the router's two output FIFOs into one registered
// byte stream with a fixed two-cycle read-to-output latency.
module egress_arbiter_2to1
   import egress_pkg::*;
#(
   parameter int DATA_W    = EGRESS_DATA_W,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] fifo0_data,
   input  logic              fifo0_empty,
   input  logic [DATA_W-1:0] fifo1_data,
   input  logic              fifo1_empty,
   input  logic              down_almost_full,
   output logic              read0,
   output logic              read1,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_src,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);

   logic              vld_p1_q, vld_p1_d;
   logic              src_p1_q, src_p1_d;
   logic              out_valid_q, out_valid_d;
   logic              out_src_q, out_src_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]  cnt0_q, cnt0_d;
   logic [CNT_W-1:0]  cnt1_q, cnt1_d;

   rr_burst_arbiter #(
      .MAX_BURST(MAX_BURST)
   ) u_arb (
      .clk              (clk),
      .reset            (reset),
      .fifo0_empty      (fifo0_empty),
      .fifo1_empty      (fifo1_empty),
      .down_almost_full (down_almost_full),
      .read0            (read0),
      .read1            (read1)
   );

   always_comb begin
      // Stage p1: a pop was issued last cycle, FIFO data is on the bus now
      vld_p1_d    = read0 || read1;
      src_p1_d    = read1;
      // Stage p2: capture the FIFO word into the output register
      out_valid_d = vld_p1_q;
      out_src_d   = vld_p1_q ? src_p1_q : out_src_q;
      out_data_d  = out_data_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
      if (vld_p1_q) begin
         out_data_d = src_p1_q ? fifo1_data : fifo0_data;
         if (src_p1_q) cnt1_d = cnt1_q + CNT_W'(1);
         else          cnt0_d = cnt0_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1_q    <= 1'b0;
         src_p1_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_src_q   <= 1'b0;
         out_data_q  <= '0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         vld_p1_q    <= vld_p1_d;
         src_p1_q    <= src_p1_d;
         out_valid_q <= out_valid_d;
         out_src_q   <= out_src_d;
         out_data_q  <= out_data_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_src   = out_src_q;
   assign out_data  = out_data_q;
   assign cnt0      = cnt0_q;
   assign cnt1      = cnt1_q;

endmodule

// File: doc/egress_arbiter_2to1.md
Name: egress_arbiter_2to1

Overview:
- Downstream stage of the two-port router.
- Drains the router's two output FIFOs (port 0 and port 1) into a single 8-bit egress stream.
- Round-robin arbitration with a bounded burst length; honours almost-full backpressure from the egress sink.
- Keeps a per-source forwarded-word count for status and debug.

Parameters:
- DATA_W, 8, width of FIFO data and of the egress data.
- MAX_BURST, 4, maximum consecutive reads from one source while the other source is non-empty; legal range 1..15.
- CNT_W, 16, width of the per-source forwarded-word counters.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo0_data  in  DATA_W  port-0 FIFO read data; valid in the cycle after read0.
- fifo0_empty  in  1  port-0 FIFO empty.
- fifo1_data  in  DATA_W  port-1 FIFO read data; valid in the cycle after read1.
- fifo1_empty  in  1  port-1 FIFO empty.
- down_almost_full  in  1  egress sink backpressure.
- read0  out  1  pop request to the port-0 FIFO.
- read1  out  1  pop request to the port-1 FIFO.
- out_data  out  DATA_W  egress word, registered.
- out_valid  out  1  out_data is valid this cycle.
- out_src  out  1  source FIFO of out_data (0 or 1).
- cnt0  out  CNT_W  words forwarded from port 0; wraps.
- cnt1  out  CNT_W  words forwarded from port 1; wraps.

Behaviour:
- Reset (checked at clk edge while reset=1), next cycle:
  - read0=read1=0, out_valid=0, out_data=0, out_src=0, cnt0=cnt1=0.
  - FSM=IDLE, burst counter=0, priority pointer=0, in-flight flags cleared.
  - Reset mid-burst discards any in-flight word; it is not emitted.
- FSM states are IDLE, SERVE0, SERVE1.
- IDLE:
  - Both FIFOs empty: stay in IDLE.
  - Otherwise go to SERVEp if FIFO p (the priority-pointer source) is non-empty, else to SERVE of the other source.
  - Burst counter cleared on entry to either SERVE state.
  - No reads are issued in IDLE.
- SERVEn, read generation:
  - readn = !fifon_empty && !down_almost_full (combinational from state and inputs).
  - The other read is always 0; read0 and read1 are never high together.
  - Each issued read increments the burst counter.
- SERVEn, leave the state when:
  - fifon_empty=1: go to SERVEm if FIFO m is non-empty, else IDLE. Pointer set to m.
  - A read is issued with burst counter = MAX_BURST-1 and the other FIFO is non-empty: go to SERVEm, pointer set to m.
  - A read is issued with burst counter = MAX_BURST-1 and the other FIFO is empty: stay in SERVEn, burst counter restarts at 0.
- Backpressure:
  - down_almost_full=1 suppresses new reads the same cycle.
  - State and burst counter are held.
  - The in-flight word still completes.
  - Sink contract: almost_full asserted with at least 2 free slots.
- Datapath, fixed latency 2:
  - Read issued in cycle t.
  - FIFO data captured at the end of cycle t+1.
  - out_valid=1 in cycle t+2, with out_src = n.
  - Back-to-back reads give back-to-back out_valid with no bubbles, including when the grant switches source.
- Counters: cnt0 or cnt1 increments in the cycle out_valid rises for that source; mod 2^CNT_W wrap, no saturation.
- Simultaneous first arrival after reset: pointer=0, so port 0 is served first.
- Reading an empty FIFO is impossible by construction; assertion: readn implies !fifon_empty.

Decomposition:
- Shared package egress_pkg:
  - state encoding constants ST_IDLE, ST_SERVE0, ST_SERVE1 (2-bit).
  - DATA_W default.
  - burst counter width BURST_W=4.
- Natural sub-module: rr_burst_arbiter.
  - Contains the FSM, burst counter and pointer.
  - Inputs: empties and down_almost_full. Outputs: read0 and read1.
- The top level holds the 2-stage valid/source pipeline, the output register and the counters.

Test Plan:
- Wait 6 cycles with reset=1, then release. Load 6 words 0xFF into port 0, port 1 empty → read0 high for 6 consecutive cycles. First out_valid exactly 2 cycles after the first read0. out_data=0xFF x6, out_src=0, cnt0=6, cnt1=0.
- Port 0 holds 8x0xEE and port 1 holds 8x0xCC, MAX_BURST=4 → egress order is 4xEE, 4xCC, 4xEE, 4xCC with no idle cycles. cnt0=cnt1=8.
- Assert down_almost_full for 3 cycles after the 2nd read of a burst → reads stop the same cycle and exactly one in-flight word is still emitted. Reads resume from the same source and that burst totals 4 reads.
- Both FIFOs become non-empty in the same cycle after reset → first read is read0. Pulse reset mid-burst → next cycle read0=read1=0, out_valid=0, counters 0. Discarded in-flight word never appears.
- CNT_W=4, forward 17 words from port 1 → cnt1=1 (wrapped). Assertion never fires.
